pc_fetch_unit: RTL and testbench



---
 rtl/pc_fetch_unit.sv | 142 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program-counter stage of the fetch path: sequential/branch/jump PC selection, stall hold,
// buffered redirect during stall. Optional range check enabled by PC_BOUND_CHECK_EN.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  input  logic        i_jump,
  input  logic [31:0] i_jump_target,
  output logic [31:0] o_pc,
  output logic        o_fetch_valid,
  output logic        o_flush,
  output logic        o_redirect_pending,
  output logic        o_pc_fault
);

  typedef enum logic [1:0] {StRun, StPend, StFault} state_e;

  state_e      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pend_target;
  logic        r_fetch_valid;
  logic        r_flush;
  logic        r_pend;
  logic        r_fault;

  state_e      w_state_next;
  logic [31:0] w_pc_next;
  logic [31:0] w_pend_target_next;
  logic        w_fetch_valid_next;
  logic        w_flush_next;
  logic        w_pend_next;
  logic        w_fault_next;

  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_load;
  logic [31:0] w_cand;
  logic        w_cand_flush;
  logic        w_out_of_range;

  // Branch belongs to the older instruction, so it wins over a same-cycle jump.
  assign w_redirect = i_branch_taken | i_jump;
  assign w_target   = i_branch_taken ? i_branch_target : i_jump_target;

`ifdef PC_BOUND_CHECK_EN
  assign w_out_of_range = (w_cand >= 32'(IMEM_DEPTH));
`else
  assign w_out_of_range = 1'b0;
`endif

  always_comb begin
    w_state_next       = r_state;
    w_pc_next          = r_pc;
    w_pend_target_next = r_pend_target;
    w_fetch_valid_next = 1'b1;
    w_flush_next       = 1'b0;
    w_pend_next        = r_pend;
    w_fault_next       = r_fault;
    w_load             = 1'b0;
    w_cand             = r_pc;
    w_cand_flush       = 1'b0;

    unique case (r_state)
      StRun: begin
        if (i_stall) begin
          if (w_redirect) begin
            w_pend_target_next = w_target;
            w_pend_next        = 1'b1;
            w_state_next       = StPend;
          end
        end else begin
          w_load       = 1'b1;
          w_cand       = w_redirect ? w_target : r_pc + 32'd1;
          w_cand_flush = w_redirect;
        end
      end
      StPend: begin
        // The buffered redirect is older than anything arriving now; new ones are dropped.
        if (!i_stall) begin
          w_load       = 1'b1;
          w_cand       = r_pend_target;
          w_cand_flush = 1'b1;
          w_pend_next  = 1'b0;
          w_state_next = StRun;
        end
      end
      StFault: begin
        w_fetch_valid_next = 1'b0;
      end
      default: begin
        w_state_next = StRun;
      end
    endcase

    if (w_load) begin
      if (w_out_of_range) begin
        w_state_next       = StFault;
        w_fault_next       = 1'b1;
        w_fetch_valid_next = 1'b0;
      end else begin
        w_pc_next    = w_cand;
        w_flush_next = w_cand_flush;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= StRun;
      r_pc          <= RESET_PC;
      r_pend_target <= 32'h0000_0000;
      r_fetch_valid <= 1'b0;
      r_flush       <= 1'b0;
      r_pend        <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_pend_target <= w_pend_target_next;
      r_fetch_valid <= w_fetch_valid_next;
      r_flush       <= w_flush_next;
      r_pend        <= w_pend_next;
      r_fault       <= w_fault_next;
    end
  end

  assign o_pc               = r_pc;
  assign o_fetch_valid      = r_fetch_valid;
  assign o_flush            = r_flush;
  assign o_redirect_pending = r_pend;
`ifdef PC_BOUND_CHECK_EN
  assign o_pc_fault         = r_fault;
`else
  assign o_pc_fault         = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: per-cycle model compare plus literal spot checks.
module tb_pc_fetch_unit;

`ifdef PC_BOUND_CHECK_EN
  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
  localparam int unsigned TB_DEPTH    = 16;
  localparam bit          TB_BOUND    = 1'b1;
`else
  localparam logic [31:0] TB_RESET_PC = 32'h0000_0010;
  localparam int unsigned TB_DEPTH    = 1024;
  localparam bit          TB_BOUND    = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, stall, bt, jmp;
  logic [31:0] btgt, jtgt;
  logic [31:0] o_pc;
  logic        o_fetch_valid, o_flush, o_redirect_pending, o_pc_fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_fetch_unit #(
    .RESET_PC  (TB_RESET_PC),
    .IMEM_DEPTH(TB_DEPTH)
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_stall           (stall),
    .i_branch_taken    (bt),
    .i_branch_target   (btgt),
    .i_jump            (jmp),
    .i_jump_target     (jtgt),
    .o_pc              (o_pc),
    .o_fetch_valid     (o_fetch_valid),
    .o_flush           (o_flush),
    .o_redirect_pending(o_redirect_pending),
    .o_pc_fault        (o_pc_fault)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the fetch stage must show after each edge.
  logic [31:0] m_pc, m_ptgt, cand;
  logic        m_valid, m_flush, m_pend, m_fault, cand_fl, chk_en = 1'b0;

  always @(posedge clk) begin
    chk_en = 1'b1;
    if (rst) begin
      m_pc = TB_RESET_PC; m_valid = 0; m_flush = 0; m_pend = 0; m_ptgt = 0; m_fault = 0;
    end else if (m_fault) begin
      m_valid = 0; m_flush = 0;
    end else begin
      m_valid = 1;
      m_flush = 0;
      if (stall) begin
        if (!m_pend && (bt || jmp)) begin
          m_pend = 1;
          m_ptgt = bt ? btgt : jtgt;
        end
      end else begin
        if (m_pend) begin
          cand = m_ptgt; cand_fl = 1; m_pend = 0;
        end else if (bt) begin
          cand = btgt; cand_fl = 1;
        end else if (jmp) begin
          cand = jtgt; cand_fl = 1;
        end else begin
          cand = m_pc + 32'd1; cand_fl = 0;
        end
        if (TB_BOUND && cand >= TB_DEPTH) begin
          m_fault = 1; m_valid = 0;
        end else begin
          m_pc = cand; m_flush = cand_fl;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_pc", o_pc, m_pc);
      chk("model_fetch_valid", 32'(o_fetch_valid), 32'(m_valid));
      chk("model_flush", 32'(o_flush), 32'(m_flush));
      chk("model_redirect_pending", 32'(o_redirect_pending), 32'(m_pend));
      chk("model_pc_fault", 32'(o_pc_fault), 32'(m_fault));
    end
  end

  // Apply inputs for one edge, then return at the following negedge.
  task automatic step(input logic r, input logic s, input logic b, input logic [31:0] bt_t,
                      input logic j, input logic [31:0] j_t);
    rst = r; stall = s; bt = b; btgt = bt_t; jmp = j; jtgt = j_t;
    @(negedge clk);
  endtask

  initial begin
    rst = 1; stall = 0; bt = 0; btgt = 0; jmp = 0; jtgt = 0;
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0);
    chk("reset_pc", o_pc, TB_RESET_PC);
    chk("reset_fetch_valid", 32'(o_fetch_valid), 32'd0);
    chk("reset_pending", 32'(o_redirect_pending), 32'd0);
`ifdef PC_BOUND_CHECK_EN
    for (int i = 0; i < 15; i++) step(0, 0, 0, 0, 0, 0);
    chk("bound_last_pc", o_pc, 32'h0000_000F);
    chk("bound_no_fault_yet", 32'(o_pc_fault), 32'd0);
    step(0, 0, 0, 0, 0, 0);
    chk("bound_hold_pc", o_pc, 32'h0000_000F);
    chk("bound_fault", 32'(o_pc_fault), 32'd1);
    chk("bound_fetch_invalid", 32'(o_fetch_valid), 32'd0);
    step(0, 0, 0, 0, 1, 32'h2);
    chk("bound_jump_ignored", o_pc, 32'h0000_000F);
    step(1, 0, 0, 0, 0, 0);
    chk("bound_rst_pc", o_pc, 32'h0000_0000);
    chk("bound_rst_clears", 32'(o_pc_fault), 32'd0);
    step(0, 0, 0, 0, 0, 0);
    chk("bound_rerun_pc", o_pc, 32'h0000_0001);
`else
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 0, 0, 0, 0);
      chk("free_pc", o_pc, 32'h10 + 32'(i));
      chk("free_flush", 32'(o_flush), 32'd0);
    end
    chk("free_fetch_valid", 32'(o_fetch_valid), 32'd1);
    step(0, 0, 0, 0, 1, 32'h20);
    chk("jump_pc", o_pc, 32'h20);
    step(0, 0, 1, 32'h80, 1, 32'h40);
    chk("branch_over_jump_pc", o_pc, 32'h80);
    chk("branch_flush", 32'(o_flush), 32'd1);
    step(0, 0, 0, 0, 0, 0);
    chk("after_branch_pc", o_pc, 32'h81);
    chk("after_branch_flush", 32'(o_flush), 32'd0);
    step(0, 0, 0, 0, 1, 32'h30);
    step(0, 1, 0, 0, 1, 32'h50);
    chk("stall_hold_pc", o_pc, 32'h30);
    chk("stall_pending", 32'(o_redirect_pending), 32'd1);
    step(0, 1, 1, 32'h90, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("stall_still_pc", o_pc, 32'h30);
    step(0, 0, 0, 0, 0, 0);
    chk("release_pc", o_pc, 32'h50);
    chk("release_flush", 32'(o_flush), 32'd1);
    chk("release_pending", 32'(o_redirect_pending), 32'd0);
    step(0, 0, 0, 0, 0, 0);
    chk("post_release_pc", o_pc, 32'h51);
    chk("single_flush", 32'(o_flush), 32'd0);
    step(0, 0, 0, 0, 1, 32'hFFFF_FFFF);
    step(0, 0, 0, 0, 0, 0);
    chk("wrap_pc", o_pc, 32'h0);
    step(0, 1, 0, 0, 1, 32'h60);
    step(0, 0, 1, 32'hA0, 0, 0);
    chk("pend_wins_release_pc", o_pc, 32'h60);
    step(0, 1, 0, 0, 1, 32'h70);
    chk("pend70_pending", 32'(o_redirect_pending), 32'd1);
    step(1, 1, 0, 0, 0, 0);
    chk("pend_rst_pc", o_pc, 32'h10);
    chk("pend_rst_pending", 32'(o_redirect_pending), 32'd0);
    step(0, 0, 0, 0, 0, 0);
    chk("pend_rst_no_70", o_pc, 32'h11);
    chk("pend_rst_no_flush", 32'(o_flush), 32'd0);
    step(0, 0, 0, 0, 0, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
